// File: rtl/times_table_pkg.sv
// Shared types and helpers for the shift-and-add times-table multiplier.
package times_table_pkg;

    localparam int DEFAULT_W = 3;
    localparam int MAX_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Callers sign-extend narrower operands to MAX_W first; -2^(MAX_W-1) maps to 2^(MAX_W-1).
    function automatic logic [MAX_W-1:0] magnitude(input logic signed [MAX_W-1:0] val);
        logic [MAX_W-1:0] val_u;
        val_u = val;
        return val_u[MAX_W-1] ? (~val_u + MAX_W'(1)) : val_u;
    endfunction

endpackage

// File: rtl/times_table_seq.sv
// Sequential W x W multiplier (unsigned or two's-complement), one multiplier bit per enabled cycle.
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   CALC  | one shift-and-add step per enabled cycle, W steps in total
//   DONE  | result valid, done asserted for one enabled cycle
module times_table_seq
    import times_table_pkg::*;
#(
    parameter int  W     = DEFAULT_W,
    localparam int CNT_W = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             neg_q, neg_d;

    logic signed [MAX_W-1:0] a_ext, b_ext;
    logic [2*W-1:0]          partial, acc_sum;

    assign a_ext = MAX_W'($signed(a));
    assign b_ext = MAX_W'($signed(b));

    assign partial = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << count_q) : '0;
    assign acc_sum = acc_q + partial;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        neg_d    = neg_q;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_d  = signed_mode ? W'(magnitude(a_ext)) : a;
                        mplier_d = signed_mode ? W'(magnitude(b_ext)) : b;
                        neg_d    = signed_mode & (a[W-1] ^ b[W-1]);
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    acc_d    = acc_sum;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                    // The last step's partial product goes straight into the result.
                    if (count_q == CNT_W'(W - 1)) begin
                        result_d = neg_q ? -acc_sum : acc_sum;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
